bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter for the seven-segment display path. It accepts already-debounced single-cycle pulses for increment, decrement, clear and parallel load, and holds DIGITS packed BCD digits for the display multiplexer. At the top/bottom of range it either wraps or saturates, selected at build time. It reports range events and rejected loads as single-cycle pulses.

## Interface
- DIGITS, 4, number of BCD digits; legal range 1..8
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- inc  in  1  increment request, one-cycle pulse (debounced upstream)
- dec  in  1  decrement request, one-cycle pulse
- clear  in  1  synchronous clear request, one-cycle pulse
- load  in  1  parallel load request, one-cycle pulse
- load_value  in  4*DIGITS  BCD load data; digit 0 (units) in bits [3:0], digit k in [4k+3:4k]
- count  out  4*DIGITS  current value, same packing as load_value
- overflow  out  1  one-cycle pulse: increment attempted at all-9s
- underflow  out  1  one-cycle pulse: decrement attempted at all-0s
- load_error  out  1  one-cycle pulse: load rejected, some nibble of load_value > 9
- at_zero  out  1  level: count == 0

## Operation
- Reset (rst high, asynchronous): count = 0, overflow = 0, underflow = 0, load_error = 0. The block holds while rst is high.
- Per-cycle priority, highest first: clear > load > (inc xor dec). Lower-priority requests in the same cycle are discarded, not queued.
- clear: count becomes 0. No event pulse.
- load:
  - If every nibble of load_value is <= 9, count becomes load_value.
  - Otherwise count is unchanged and load_error pulses.
- inc and dec both high in the same cycle: net zero, count unchanged, no pulses.
- Increment, digit-serial carry within one cycle:
  - Digit 0 adds 1.
  - Any digit at 9 that receives a carry becomes 0 and propagates the carry to the next digit.
  - Other digits are unchanged.
- Decrement, same structure with borrow:
  - Digit 0 subtracts 1.
  - Any digit at 0 that receives a borrow becomes 9 and propagates the borrow.
- Range end, increment from all 9s:
  - SATURATE=0: count becomes all 0s.
  - SATURATE=1: count stays all 9s.
  - Both modes: overflow pulses.
- Range end, decrement from all 0s:
  - SATURATE=0: count becomes all 9s.
  - SATURATE=1: count stays 0.
  - Both modes: underflow pulses.
- Arithmetic stays on BCD nibbles; no binary conversion. Every nibble of count is <= 9 at all times.
- at_zero is decoded combinationally from the count register.

## Timing
- Latency 1: a request sampled high at edge N shows its result on count after edge N.
- overflow, underflow and load_error are registered. Each is high for exactly the cycle after edge N, aligned with the updated count, and low otherwise.
- Back-to-back pulses on consecutive cycles are each honoured; required throughput is one operation per clock.
- at_zero follows count with no extra cycle.
- rst asserted mid-operation clears count and all pulses immediately, without waiting for clk. The first operation after release is taken at the first rising edge with rst low.
- The carry/borrow chain must close within one clk period for DIGITS up to 8.

## Test plan
- Reset and zero check, DIGITS=4: assert rst asynchronously mid-cycle with count=0x1234 -> count=0x0000 without a clk edge; at_zero=1; all pulses 0.
- Carry ripple, DIGITS=4, SATURATE=0: load 0x0999, then one inc -> count=0x1000 next cycle, overflow=0. Then load 0x9999 and inc -> count=0x0000, overflow high for exactly 1 cycle.
- Borrow and saturation, DIGITS=4, SATURATE=1:
  - From 0x1000, one dec -> count=0x0999.
  - From 0x0000, dec -> stays 0x0000, underflow pulses once.
  - From 0x9999, inc -> stays 0x9999, overflow pulses once.
- Priority and cancellation:
  - clear+load+inc in one cycle with count=0x0042 -> count=0x0000, no pulses.
  - load(0x0123)+inc together -> count=0x0123.
  - inc+dec together -> count unchanged.
- Invalid load: count=0x0005, load 0x12A4 -> count stays 0x0005, load_error high for 1 cycle. A following load of 0x0987 -> count=0x0987, load_error=0.
- Throughput: 25 consecutive inc pulses from 0x0000, DIGITS=2 -> count=0x25. Check every nibble is <= 9 on every cycle.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with clear, validated parallel load,
// wrap-or-saturate range handling and registered single-cycle event pulses.
module bcd_updown_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                overflow,
  output logic                underflow,
  output logic                load_error,
  output logic                at_zero
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] inc_value;
  logic [W-1:0] dec_value;
  logic [W-1:0] count_next;
  logic         carry_out;
  logic         borrow_out;
  logic         load_ok;
  logic         overflow_next;
  logic         underflow_next;
  logic         load_error_next;

  // Digit-serial carry and borrow chains; a surviving carry/borrow marks all-9s/all-0s.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] digit;
    logic [3:0] ld_digit;
    carry     = 1'b1;
    borrow    = 1'b1;
    load_ok   = 1'b1;
    digit     = '0;
    ld_digit  = '0;
    inc_value = '0;
    dec_value = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = count[4*k +: 4];
      if (carry && digit == 4'd9) begin
        inc_value[4*k +: 4] = 4'd0;
      end else if (carry) begin
        inc_value[4*k +: 4] = digit + 4'd1;
        carry = 1'b0;
      end else begin
        inc_value[4*k +: 4] = digit;
      end
      if (borrow && digit == 4'd0) begin
        dec_value[4*k +: 4] = 4'd9;
      end else if (borrow) begin
        dec_value[4*k +: 4] = digit - 4'd1;
        borrow = 1'b0;
      end else begin
        dec_value[4*k +: 4] = digit;
      end
      ld_digit = load_value[4*k +: 4];
      if (ld_digit > 4'd9) load_ok = 1'b0;
    end
    carry_out  = carry;
    borrow_out = borrow;
  end

  // Wrapping falls out of the chains themselves; saturation just holds the value.
  always_comb begin
    count_next      = count;
    overflow_next   = 1'b0;
    underflow_next  = 1'b0;
    load_error_next = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      if (load_ok) count_next = load_value;
      else         load_error_next = 1'b1;
    end else if (inc && !dec) begin
      overflow_next = carry_out;
      if (!(carry_out && SATURATE)) count_next = inc_value;
    end else if (dec && !inc) begin
      underflow_next = borrow_out;
      if (!(borrow_out && SATURATE)) count_next = dec_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      count      <= count_next;
      overflow   <= overflow_next;
      underflow  <= underflow_next;
      load_error <= load_error_next;
    end
  end

  assign at_zero = (count == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Drives wrap (4 digits), saturate (4 digits) and wrap (2 digits) counters with
// shared directed and random requests, checked against a decimal-integer model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst, inc, dec, clear, load;
  logic [15:0] lv;
  logic [15:0] cnt_w, cnt_s;
  logic [7:0]  cnt_t;
  logic        ov_w, ud_w, le_w, az_w;
  logic        ov_s, ud_s, le_s, az_s;
  logic        ov_t, ud_t, le_t, az_t;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int m_val [3];
  bit m_ov  [3];
  bit m_ud  [3];
  bit m_le  [3];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clear(clear), .load(load),
    .load_value(lv), .count(cnt_w), .overflow(ov_w), .underflow(ud_w),
    .load_error(le_w), .at_zero(az_w));

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clear(clear), .load(load),
    .load_value(lv), .count(cnt_s), .overflow(ov_s), .underflow(ud_s),
    .load_error(le_s), .at_zero(az_s));

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) u_t (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clear(clear), .load(load),
    .load_value(lv[7:0]), .count(cnt_t), .overflow(ov_t), .underflow(ud_t),
    .load_error(le_t), .at_zero(az_t));

  function automatic int digitsOf(int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic int maxOf(int d);
    int m = 1;
    repeat (d) m = m * 10;
    return m - 1;
  endfunction

  function automatic bit bcdValid(logic [31:0] v, int d);
    for (int k = 0; k < d; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(logic [31:0] v, int d);
    int s = 0;
    for (int k = d - 1; k >= 0; k--) s = s * 10 + int'(v[4*k +: 4]);
    return s;
  endfunction

  function automatic logic [31:0] int2bcd(int n, int d);
    logic [31:0] r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_val[i] = 0; m_ov[i] = 0; m_ud[i] = 0; m_le[i] = 0;
    end
  endtask

  // Reference behaviour in plain decimal arithmetic on the counter value.
  task automatic modelStep(bit i_inc, bit i_dec, bit i_clr, bit i_ld, logic [15:0] v);
    for (int i = 0; i < 3; i++) begin
      int  d   = digitsOf(i);
      int  mx  = maxOf(d);
      bit  sat = (i == 1);
      m_ov[i] = 0; m_ud[i] = 0; m_le[i] = 0;
      if (i_clr) begin
        m_val[i] = 0;
      end else if (i_ld) begin
        if (bcdValid({16'h0, v}, d)) m_val[i] = bcd2int({16'h0, v}, d);
        else m_le[i] = 1;
      end else if (i_inc && !i_dec) begin
        if (m_val[i] == mx) begin
          m_ov[i] = 1;
          m_val[i] = sat ? mx : 0;
        end else m_val[i] = m_val[i] + 1;
      end else if (i_dec && !i_inc) begin
        if (m_val[i] == 0) begin
          m_ud[i] = 1;
          m_val[i] = sat ? 0 : mx;
        end else m_val[i] = m_val[i] - 1;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkInst(string tag, int i, logic [31:0] c, logic ov, logic ud,
                           logic le, logic az);
    int d = digitsOf(i);
    check({tag, " count"},      c, int2bcd(m_val[i], d));
    check({tag, " nibbles"},    32'(bcdValid(c, d)), 32'd1);
    check({tag, " overflow"},   32'(ov), 32'(m_ov[i]));
    check({tag, " underflow"},  32'(ud), 32'(m_ud[i]));
    check({tag, " load_error"}, 32'(le), 32'(m_le[i]));
    check({tag, " at_zero"},    32'(az), 32'(m_val[i] == 0));
  endtask

  task automatic checkOutput(string where);
    checkInst({where, "/wrap4"}, 0, {16'h0, cnt_w}, ov_w, ud_w, le_w, az_w);
    checkInst({where, "/sat4"},  1, {16'h0, cnt_s}, ov_s, ud_s, le_s, az_s);
    checkInst({where, "/wrap2"}, 2, {24'h0, cnt_t}, ov_t, ud_t, le_t, az_t);
  endtask

  // Called at a falling edge: requests are sampled at the next rising edge and
  // the results are checked at the following falling edge.
  task automatic applyStimulus(string where, bit i_inc, bit i_dec, bit i_clr, bit i_ld,
                               logic [15:0] v);
    inc = i_inc; dec = i_dec; clear = i_clr; load = i_ld; lv = v;
    @(negedge clk);
    modelStep(i_inc, i_dec, i_clr, i_ld, v);
    inc = 0; dec = 0; clear = 0; load = 0;
    checkOutput(where);
  endtask

  task automatic asyncReset(string where);
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput(where);
    @(negedge clk);
    checkOutput({where, " held"});
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rv;
    int r;
    rst = 1'b1; inc = 0; dec = 0; clear = 0; load = 0; lv = '0;
    modelReset();
    @(negedge clk);
    checkOutput("reset");
    rst = 1'b0;

    applyStimulus("load1234", 0, 0, 0, 1, 16'h1234);
    asyncReset("async_rst");

    applyStimulus("load0999", 0, 0, 0, 1, 16'h0999);
    applyStimulus("carry",    1, 0, 0, 0, 16'h0);
    applyStimulus("load9999", 0, 0, 0, 1, 16'h9999);
    applyStimulus("inc_top",  1, 0, 0, 0, 16'h0);
    applyStimulus("idle1",    0, 0, 0, 0, 16'h0);
    applyStimulus("load1000", 0, 0, 0, 1, 16'h1000);
    applyStimulus("borrow",   0, 1, 0, 0, 16'h0);
    applyStimulus("clear",    0, 0, 1, 0, 16'h0);
    applyStimulus("dec_bot",  0, 1, 0, 0, 16'h0);
    applyStimulus("idle2",    0, 0, 0, 0, 16'h0);
    applyStimulus("load0042", 0, 0, 0, 1, 16'h0042);
    applyStimulus("clr_ld_inc", 1, 0, 1, 1, 16'h0777);
    applyStimulus("ld_inc",   1, 0, 0, 1, 16'h0123);
    applyStimulus("inc_dec",  1, 1, 0, 0, 16'h0);
    applyStimulus("load0005", 0, 0, 0, 1, 16'h0005);
    applyStimulus("bad_load", 0, 0, 0, 1, 16'h12A4);
    applyStimulus("load0987", 0, 0, 0, 1, 16'h0987);

    applyStimulus("clear2", 0, 0, 1, 0, 16'h0);
    for (int n = 0; n < 25; n++) applyStimulus("burst", 1, 0, 0, 0, 16'h0);
    check("burst wrap2 final", {24'h0, cnt_t}, 32'h25);

    applyStimulus("load9999b", 0, 0, 0, 1, 16'h9999);
    applyStimulus("inc_top2",  1, 0, 0, 0, 16'h0);
    asyncReset("rst_in_pulse");

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++)
        rv[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      r = $urandom_range(0, 99);
      if (r < 4)       applyStimulus("rnd_clear", 0, 0, 1, $urandom_range(0, 1) == 1, rv);
      else if (r < 14) applyStimulus("rnd_load", $urandom_range(0, 1) == 1, 0, 0, 1, rv);
      else if (r < 52) applyStimulus("rnd_inc", 1, 0, 0, 0, rv);
      else if (r < 88) applyStimulus("rnd_dec", 0, 1, 0, 0, rv);
      else if (r < 93) applyStimulus("rnd_both", 1, 1, 0, 0, rv);
      else             applyStimulus("rnd_idle", 0, 0, 0, 0, rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
